bitonic_sort_pipe: RTL
======================

Name: bitonic_sort_pipe

Overview:
- Parametrised, pipelined bitonic sorting network for N = 2^LOG_N keys of W bits each.
- Supersedes the fixed 8-lane, 1-bit combinational sorter.
- Adds multi-bit unsigned keys, a per-vector ascending/descending mode, one registered compare-exchange layer per network stage, and a valid/ready stream handshake with backpressure and bubble collapse.
- Sits between a vector producer and consumer in the sort datapath at a throughput of one vector per cycle.

Parameters:
- LOG_N, 3, log2 of lane count; N = 2^LOG_N, legal range 1..5.
- W, 8, key width in bits, unsigned, legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_desc hold a vector.
- in_ready  output  1  block accepts the vector this cycle.
- in_data  input  N*W  lane i = in_data[i*W +: W].
- in_desc  input  1  1 = descending, 0 = ascending; travels with its vector.
- out_valid  output  1  out_data holds a sorted vector.
- out_ready  input  1  consumer accepts this cycle.
- out_data  output  N*W  sorted vector, lane i = out_data[i*W +: W].
- out_desc  output  1  mode the vector was sorted with.

Behaviour:
- Stage count S = LOG_N*(LOG_N+1)/2; S = 6 for N = 8.
- Each stage is one layer of N/2 compare-exchange cells followed by a register holding N*W data, 1 desc bit and 1 valid bit.
- Network: standard bitonic merge.
  - Phase p = 1..LOG_N, sub-step j = p-1 down to 0.
  - Lane i pairs with lane i XOR 2^j, and the lower index holds the min.
  - The min/max sense is inverted when bit p of i is set, except in the final phase.
  - When desc = 1, every cell's sense is additionally inverted.
- Ordering result:
  - Ascending: lane 0 = smallest, lane N-1 = largest.
  - Descending: the reverse.
  - The output multiset equals the input multiset.
  - Equal keys are interchangeable; stability is not required.
- Comparison is unsigned, full W bits. No width growth or truncation.
- Handshake:
  - A transfer occurs at a rising edge where valid and ready are both high.
  - in_valid is not required to stay high without acceptance, but data must be stable whenever in_valid is high.
- Stage k advances when its successor is ready: ready_k = !valid_k || ready_(k+1), with ready_S = out_ready. in_ready = ready_1.
  - This ready chain is combinational; no combinational path from in_valid to in_ready.
- Bubble collapse: an empty stage accepts regardless of downstream stall. Capacity = S vectors in flight.
- Latency:
  - A vector accepted at edge t is presented on out_* after edge t+S-1.
  - It is consumable at edge t+S at the earliest.
  - With out_ready held high, throughput is 1 vector/cycle.
- Order: vectors exit strictly in acceptance order; none are dropped or duplicated.
- out_valid/out_data/out_desc are direct stage-S register outputs. They hold stable while out_valid && !out_ready.
- Reset (async assert, sync-release handled upstream):
  - All valid bits = 0, all data/desc registers = 0.
  - out_valid = 0, out_data = 0, out_desc = 0.
  - in_ready = 1 from the first edge after release.
- Reset mid-operation discards all in-flight vectors; nothing from before reset is ever emitted.
- Degenerate LOG_N = 1: S = 1, a single compare-exchange register.

Decomposition:
- Package bitonic_pkg:
  - Function for stage count S(LOG_N).
  - Functions mapping stage index to (phase p, sub-step j).
  - Partner-index and direction-bit helper functions, usable in generate loops.
- Sub-module bitonic_cas_stage, parametrised by N, W, P, J:
  - One compare-exchange layer plus its pipeline register and valid/ready slot.
  - Top level generates S instances and chains them.

Test Plan:
- Reset: hold rst_n = 0 mid-cycle, release -> out_valid = 0, out_data = 0, in_ready = 1; no output for S cycles with in_valid = 0.
- Ascending, N=8, W=8: lanes 0..7 = {7,3,5,1,0,6,2,4}, in_desc = 0, out_ready = 1 -> out_data lanes = {0,1,2,3,4,5,6,7}, out_valid exactly S = 6 cycles after acceptance, out_desc = 0.
- Descending, same input with in_desc = 1 -> lanes = {7,6,5,4,3,2,1,0}, out_desc = 1. Alternate asc/desc on back-to-back vectors -> each sorted per its own flag.
- Streaming: 100 random vectors back-to-back, out_ready = 1 -> one output per cycle after the initial 6-cycle fill. Order and content match a reference-model sort.
- Backpressure: out_ready = 0 while streaming -> exactly 6 vectors accepted, then in_ready = 0 and out_data stable. Random out_ready toggling thereafter -> no loss, duplication or reordering.
- Corner keys and reset: all lanes 0xFF; mix of 0x00/0xFF duplicates; W=1, LOG_N=4 build -> correct sort. rst_n pulsed with 4 vectors in flight -> out_valid = 0 immediately and none of the 4 ever appear.

Source files
------------

// File: rtl/bitonic_sort_pipe_pkg.sv
// Shared helpers for the pipelined bitonic sorter: stage count,
// stage-to-(phase, sub-step) mapping and per-lane cell wiring.
package bitonic_pkg;

   // Number of compare-exchange layers for 2^log_n lanes.
   function automatic int unsigned num_stages(input int unsigned log_n);
      return (log_n * (log_n + 1)) / 2;
   endfunction

   // Phase p (1..log_n) of the 0-based stage k.
   function automatic int unsigned stage_phase(input int unsigned log_n, input int unsigned k);
      int unsigned idx = 0;
      int unsigned res = 1;
      for (int unsigned p = 1; p <= log_n; p++) begin
         for (int unsigned j = p; j > 0; j--) begin
            if (idx == k) res = p;
            idx++;
         end
      end
      return res;
   endfunction

   // Sub-step j (p-1 down to 0) of the 0-based stage k.
   function automatic int unsigned stage_sub(input int unsigned log_n, input int unsigned k);
      int unsigned idx = 0;
      int unsigned res = 0;
      for (int unsigned p = 1; p <= log_n; p++) begin
         for (int unsigned j = p; j > 0; j--) begin
            if (idx == k) res = j - 1;
            idx++;
         end
      end
      return res;
   endfunction

   // Lane paired with lane i at sub-step j.
   function automatic int unsigned partner(input int unsigned i, input int unsigned j);
      return i ^ (32'd1 << j);
   endfunction

   // True when lane i is the lower index of its pair at sub-step j.
   function automatic logic is_low(input int unsigned i, input int unsigned j);
      return ((i >> j) & 32'd1) == 32'd0;
   endfunction

   // Cell sense inversion for the pair whose lower lane is lo, in phase p.
   function automatic logic cell_invert(input int unsigned lo, input int unsigned p,
                                        input int unsigned log_n);
      return (p != log_n) && (((lo >> p) & 32'd1) != 32'd0);
   endfunction

endpackage

// File: rtl/bitonic_sort_pipe_cas_stage.sv
// One bitonic compare-exchange layer with its pipeline register and
// valid/ready slot. An empty slot accepts regardless of downstream stall.
module bitonic_cas_stage
   import bitonic_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = 8,
   parameter int unsigned P = 1,
   parameter int unsigned J = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           up_valid,
   output logic           up_ready,
   input  logic [N*W-1:0] up_data,
   input  logic           up_desc,
   output logic           dn_valid,
   input  logic           dn_ready,
   output logic [N*W-1:0] dn_data,
   output logic           dn_desc
);

   localparam int unsigned LOG_N = $clog2(N);

   logic [N*W-1:0] cas_data;

   for (genvar i = 0; i < N; i++) begin : g_lane
      localparam int unsigned Q     = partner(i, J);
      localparam logic        IS_LO = is_low(i, J);
      localparam int unsigned LO    = IS_LO ? i : Q;
      localparam logic        INV   = cell_invert(LO, P, LOG_N);

      logic [W-1:0] a, b, mn, mx;
      logic         up;

      assign a  = up_data[i*W +: W];
      assign b  = up_data[Q*W +: W];
      assign mn = (a < b) ? a : b;
      assign mx = (a < b) ? b : a;
      // up = 1: lower lane of the pair takes the minimum
      assign up = ~(INV ^ up_desc);
      assign cas_data[i*W +: W] = (IS_LO == up) ? mn : mx;
   end

   assign up_ready = !dn_valid || dn_ready;

   // Pipeline register: load when this slot is free or being drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dn_valid <= 1'b0;
         dn_data  <= '0;
         dn_desc  <= 1'b0;
      end else if (up_ready) begin
         dn_valid <= up_valid;
         if (up_valid) begin
            dn_data <= cas_data;
            dn_desc <= up_desc;
         end
      end
   end

endmodule

// File: rtl/bitonic_sort_pipe.sv
// Pipelined bitonic sorter: S registered compare-exchange stages chained
// with a combinational ready path; one vector per cycle, ascending or
// descending per vector.
module bitonic_sort_pipe
   import bitonic_pkg::*;
#(
   parameter int unsigned LOG_N = 3,
   parameter int unsigned W     = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [(W<<LOG_N)-1:0]     in_data,
   input  logic                      in_desc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [(W<<LOG_N)-1:0]     out_data,
   output logic                      out_desc
);

   localparam int unsigned N = 1 << LOG_N;
   localparam int unsigned S = num_stages(LOG_N);

   // Per-stage signals live in their own generate scope so the ready
   // chain is a set of distinct nets rather than one self-referencing array.
   for (genvar k = 0; k < S; k++) begin : g_st
      logic           up_v, up_ds, up_rdy, dn_rdy, v, ds;
      logic [N*W-1:0] up_d, d;

      if (k == 0) begin : g_first
         assign up_v  = in_valid;
         assign up_d  = in_data;
         assign up_ds = in_desc;
      end else begin : g_next
         assign up_v  = g_st[k-1].v;
         assign up_d  = g_st[k-1].d;
         assign up_ds = g_st[k-1].ds;
      end

      if (k == S - 1) begin : g_last
         assign dn_rdy = out_ready;
      end else begin : g_mid
         assign dn_rdy = g_st[k+1].up_rdy;
      end

      bitonic_cas_stage #(
         .N (N),
         .W (W),
         .P (stage_phase(LOG_N, k)),
         .J (stage_sub(LOG_N, k))
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .up_valid (up_v),
         .up_ready (up_rdy),
         .up_data  (up_d),
         .up_desc  (up_ds),
         .dn_valid (v),
         .dn_ready (dn_rdy),
         .dn_data  (d),
         .dn_desc  (ds)
      );
   end

   assign in_ready  = g_st[0].up_rdy;
   assign out_valid = g_st[S-1].v;
   assign out_data  = g_st[S-1].d;
   assign out_desc  = g_st[S-1].ds;

endmodule
